rf_fifo_ctrl: RTL and testbench

- FIFO controller that uses the 32x32 register file as its storage array.
- Sits directly upstream of the register file. Drives its write port (wa/wd/we) and read port 0 (ra0); consumes rd0.
- Push and pop requests come from button-level inputs and are edge-detected internally.
- Exposes full, empty, count and a registered data output for the board display.

---
 rtl/rf_fifo_ctrl.sv | 136 +++++++++++++
 tb/tb_rf_fifo_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/rf_fifo_ctrl.sv
// rf_fifo_ctrl - FIFO controller that uses an external 32x32 register file as
// its storage array. Push/pop requests are button-level inputs and are
// edge-detected here; each accepted push writes one RF entry and each accepted
// pop captures the head entry into a registered display output.
//
// Optional feature macro: FIFO_ERR_EN (adds a sticky error output).
//
// Parameters:
//   AW    pointer width, depth = 2**AW entries (1..5)
//   BASE  first register-file address used (BASE + 2**AW <= 32)
//
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   en_in    push request level (push attempted on 0->1)
//   en_out   pop request level (pop attempted on 0->1)
//   din      push data
//   dout     last popped word, registered
//   full     occupancy == 2**AW
//   empty    occupancy == 0
//   count    occupancy, AW+1 bits
//   rf_wa    register-file write address
//   rf_wd    register-file write data
//   rf_we    register-file write enable
//   rf_ra0   register-file read address 0
//   rf_rd0   register-file read data 0 (combinational read)
//   err      (FIFO_ERR_EN only) sticky flag for any rejected request
module rf_fifo_ctrl #(
  parameter int AW   = 3,
  parameter int BASE = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_in,
  input  logic          en_out,
  input  logic [31:0]   din,
  output logic [31:0]   dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic [4:0]    rf_wa,
  output logic [31:0]   rf_wd,
  output logic          rf_we,
  output logic [4:0]    rf_ra0,
  input  logic [31:0]   rf_rd0
`ifdef FIFO_ERR_EN
  ,
  output logic          err
`endif
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(1) << AW;
  localparam logic [4:0]  BASE_C  = 5'(BASE);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;
  logic [31:0]   dout_q,   dout_d;
  logic          en_in_q,  en_out_q;

  logic push_req, pop_req;
  logic push_ok,  pop_ok;

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = dout_q;

  // Gating with rst keeps rf_we low during reset and lets reset win over
  // any request arriving in the same cycle.
  always_comb begin
    push_req = en_in  & ~en_in_q;
    pop_req  = en_out & ~en_out_q;
    pop_ok   = pop_req & ~empty & ~rst;
    // When full, a simultaneous pop frees the read slot, which is also the
    // write slot (wr_ptr == rd_ptr); the old word is read out on the same edge.
    push_ok  = push_req & (~full | pop_ok) & ~rst;
  end

  assign rf_we  = push_ok;
  assign rf_wa  = BASE_C + 5'(wr_ptr_q);
  assign rf_wd  = din;
  assign rf_ra0 = BASE_C + 5'(rd_ptr_q);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      dout_d   = rf_rd0;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      // History held high so a button pressed through reset is not an edge.
      en_in_q  <= 1'b1;
      en_out_q <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      en_in_q  <= en_in;
      en_out_q <= en_out;
    end
  end

`ifdef FIFO_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q | (push_req & ~push_ok) | (pop_req & ~pop_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_rf_fifo_ctrl.sv
module tb_rf_fifo_ctrl;
  localparam int AW    = 3;
  localparam int BASE  = 1;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en_in = 1'b1;
  logic          en_out = 1'b1;
  logic [31:0]   din = '0;
  logic [31:0]   dout;
  logic          full, empty;
  logic [AW:0]   count;
  logic [4:0]    rf_wa, rf_ra0;
  logic [31:0]   rf_wd, rf_rd0;
  logic          rf_we;
`ifdef FIFO_ERR_EN
  logic          err;
`endif

  rf_fifo_ctrl #(.AW(AW), .BASE(BASE)) dut (
    .clk(clk), .rst(rst), .en_in(en_in), .en_out(en_out), .din(din),
    .dout(dout), .full(full), .empty(empty), .count(count),
    .rf_wa(rf_wa), .rf_wd(rf_wd), .rf_we(rf_we), .rf_ra0(rf_ra0),
    .rf_rd0(rf_rd0)
`ifdef FIFO_ERR_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  // Register file the controller drives
  logic [31:0] mem [32];
  initial for (int i = 0; i < 32; i++) mem[i] = $urandom;
  always @(posedge clk) if (rf_we) mem[rf_wa] <= rf_wd;
  assign rf_rd0 = mem[rf_ra0];

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of stored words plus push/pop totals
  logic [31:0] q[$];
  logic        prev_in = 1'b1, prev_out = 1'b1;
  logic [31:0] dout_m = '0;
  logic        err_m = 1'b0;
  int          n_push = 0, n_pop = 0;

  function automatic void decide(output bit p_ok, output bit o_ok,
                                 output bit p_req, output bit o_req);
    p_req = en_in && !prev_in;
    o_req = en_out && !prev_out;
    o_ok  = o_req && (q.size() > 0) && !rst;
    p_ok  = p_req && ((q.size() < DEPTH) || o_ok) && !rst;
  endfunction

  always @(posedge clk) begin
    bit p_ok, o_ok, p_req, o_req;
    decide(p_ok, o_ok, p_req, o_req);
    if (rst) begin
      q.delete();
      prev_in = 1'b1; prev_out = 1'b1;
      dout_m = '0; err_m = 1'b0; n_push = 0; n_pop = 0;
    end else begin
      if (o_ok) begin dout_m = q.pop_front(); n_pop++; end
      if (p_ok) begin q.push_back(din); n_push++; end
      if ((p_req && !p_ok) || (o_req && !o_ok)) err_m = 1'b1;
      prev_in = en_in; prev_out = en_out;
    end
  end

  // Compare process: inputs change at negedge, outputs checked 2 ns later
  always @(negedge clk) begin
    bit p_ok, o_ok, p_req, o_req;
    #2;
    decide(p_ok, o_ok, p_req, o_req);
    chk("rf_we", rf_we, p_ok);
    if (p_ok) begin
      chk("rf_wa", rf_wa, BASE + (n_push % DEPTH));
      chk("rf_wd", rf_wd, din);
    end
    chk("rf_ra0", rf_ra0, BASE + (n_pop % DEPTH));
    chk("count", count, q.size());
    chk("empty", empty, q.size() == 0);
    chk("full", full, q.size() == DEPTH);
    chk("dout", dout, dout_m);
`ifdef FIFO_ERR_EN
    chk("err", err, err_m);
`endif
  end

  task automatic cyc(input logic ei, input logic eo, input logic [31:0] d, input logic r);
    @(negedge clk);
    en_in = ei; en_out = eo; din = d; rst = r;
  endtask

  task automatic do_push(input logic [31:0] d);
    cyc(1, 0, d, 0);
    cyc(0, 0, d, 0);
  endtask

  task automatic do_pop();
    cyc(0, 1, 32'h0, 0);
    cyc(0, 0, 32'h0, 0);
  endtask

  initial begin
    logic [31:0] v;
    // Buttons held through reset: no operation afterwards
    repeat (3) cyc(1, 1, 32'hFFFF_FFFF, 1);
    cyc(1, 1, 32'hFFFF_FFFF, 0);
    #3;
    chk("lit_hold_we", rf_we, 1'b0);
    cyc(1, 1, 32'hFFFF_FFFF, 0);
    #3;
    chk("lit_hold_count", count, 0);
    chk("lit_hold_empty", empty, 1'b1);
    chk("lit_hold_full", full, 1'b0);
    cyc(0, 0, 32'h0, 0);

    // Two pushes then two pops
    cyc(1, 0, 32'h8765_4321, 0); #3;
    chk("lit_wa1", rf_wa, 5'd1);
    chk("lit_we1", rf_we, 1'b1);
    cyc(0, 0, 32'h0, 0);
    cyc(1, 0, 32'h1234_5678, 0); #3;
    chk("lit_wa2", rf_wa, 5'd2);
    cyc(0, 0, 32'h0, 0); #3;
    chk("lit_count2", count, 2);
    do_pop(); #3;
    chk("lit_pop1", dout, 32'h8765_4321);
    do_pop(); #3;
    chk("lit_pop2", dout, 32'h1234_5678);
    chk("lit_empty2", empty, 1'b1);

    // Fill and overflow
    for (int i = 0; i < DEPTH; i++) do_push(32'h1000_0000 + i);
    #3;
    chk("lit_full", full, 1'b1);
    chk("lit_count8", count, 8);
    cyc(1, 0, 32'hDEAD_BEEF, 0); #3;
    chk("lit_ovf_we", rf_we, 1'b0);
    cyc(0, 0, 32'h0, 0); #3;
    chk("lit_ovf_count", count, 8);
`ifdef FIFO_ERR_EN
    chk("lit_ovf_err", err, 1'b1);
`endif

    // Simultaneous push/pop while full
    cyc(1, 1, 32'hA5A5_A5A5, 0); #3;
    chk("lit_both_we", rf_we, 1'b1);
    cyc(0, 0, 32'h0, 0); #3;
    chk("lit_both_dout", dout, 32'h1000_0000);
    chk("lit_both_count", count, 8);
    for (int i = 0; i < DEPTH; i++) do_pop();
    #3;
    chk("lit_last_dout", dout, 32'hA5A5_A5A5);
    chk("lit_drain_empty", empty, 1'b1);

    // Pointer wrap from a fresh reset
    cyc(0, 0, 32'h0, 1);
    cyc(0, 0, 32'h0, 0);
    for (int i = 0; i < 12; i++) begin
      v = $urandom;
      cyc(1, 0, v, 0); #3;
      chk("lit_wrap_wa", rf_wa, 5'(1 + (i % 8)));
      cyc(0, 0, 32'h0, 0);
      do_pop(); #3;
      chk("lit_wrap_dout", dout, v);
    end

    // Pop on empty after reset
    cyc(0, 0, 32'h0, 1);
    cyc(0, 0, 32'h0, 0);
    do_pop(); #3;
    chk("lit_uf_dout", dout, 32'h0);
    chk("lit_uf_count", count, 0);
`ifdef FIFO_ERR_EN
    chk("lit_uf_err", err, 1'b1);
    cyc(0, 0, 32'h0, 1);
    cyc(0, 0, 32'h0, 0); #3;
    chk("lit_rst_err", err, 1'b0);
`endif

    // Randomized traffic with phase-dependent push/pop bias and rare resets
    for (int i = 0; i < 3000; i++) begin
      int pp;
      pp = ((i / 300) % 2 == 0) ? 70 : 30;
      cyc(($urandom_range(0, 99) < pp) ? 1'b1 : 1'b0,
          ($urandom_range(0, 99) < (100 - pp)) ? 1'b1 : 1'b0,
          $urandom,
          ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
    end
    cyc(0, 0, 32'h0, 0);
    repeat (2) @(negedge clk);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
